// File: rtl/dac_sample_sched.sv
// Sample-rate scheduler: round-robin merge of two producers into a small FIFO,
// one sample per DIV-cycle period to the DAC, with click-free ramps on mute.
module dac_sample_sched #(
  parameter int MSBI  = 7,
  parameter int DIV   = 256,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          S0_VALID,
  input  logic [MSBI:0] S0_DATA,
  output logic          S0_READY,
  input  logic          S1_VALID,
  input  logic [MSBI:0] S1_DATA,
  output logic          S1_READY,
  input  logic          MUTE,
  output logic [MSBI:0] DAC_DATA,
  output logic          DAC_CEN,
  output logic          MUTED,
  output logic [7:0]    UNDERRUN
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = AW + 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [MSBI:0] MID = {1'b1, {MSBI{1'b0}}};

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RAMP_DN = 2'd1,
    ST_MUTED   = 2'd2,
    ST_RAMP_UP = 2'd3
  } state_t;

  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          tick;
  state_t        state_q, state_d;
  logic [MSBI:0] dac_q, dac_d;
  logic          cen_q, cen_d;
  logic [7:0]    und_q, und_d;
  logic          rr_q, rr_d;

  logic [MSBI:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          full, empty;
  logic          push, pop;
  logic [MSBI:0] push_dat, head;

  function automatic logic [MSBI:0] step_toward(input logic [MSBI:0] cur,
                                                input logic [MSBI:0] tgt);
    return (cur < tgt) ? cur + 1'b1 : cur - 1'b1;
  endfunction

  assign tick   = (tcnt_q == CW'(DIV - 1));
  assign tcnt_d = tick ? '0 : tcnt_q + 1'b1;

  assign full  = (fcnt_q == FW'(DEPTH));
  assign empty = (fcnt_q == '0);
  assign head  = mem_q[rd_q];

  // Nothing is accepted while RESET is high: the FIFO would drop it anyway.
  assign S0_READY = !RESET && !full && S0_VALID && (!S1_VALID || !rr_q);
  assign S1_READY = !RESET && !full && S1_VALID && (!S0_VALID ||  rr_q);
  assign push     = S0_READY || S1_READY;
  assign push_dat = S0_READY ? S0_DATA : S1_DATA;
  assign rr_d     = (S0_VALID && S1_VALID && push) ? ~rr_q : rr_q;

  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    cen_d   = 1'b0;
    und_d   = und_q;
    pop     = 1'b0;
    if (tick) begin
      case (state_q)
        ST_RUN: begin
          if (MUTE) begin
            state_d = ST_RAMP_DN;
          end else if (!empty) begin
            pop   = 1'b1;
            dac_d = head;
            cen_d = 1'b1;
          end else if (und_q != 8'hFF) begin
            und_d = und_q + 8'd1;
          end
        end
        ST_RAMP_DN: begin
          if (!MUTE) begin
            state_d = ST_RAMP_UP;
          end else if (dac_q == MID) begin
            state_d = ST_MUTED;
          end else begin
            dac_d = step_toward(dac_q, MID);
            cen_d = 1'b1;
          end
        end
        ST_MUTED: begin
          if (!MUTE) begin
            state_d = ST_RAMP_UP;
          end else if (!empty) begin
            pop = 1'b1;
          end
        end
        default: begin
          // Ramp toward the head without consuming it; RUN pops it next tick.
          if (MUTE) begin
            state_d = ST_RAMP_DN;
          end else if (empty || (dac_q == head)) begin
            state_d = ST_RUN;
          end else begin
            dac_d = step_toward(dac_q, head);
            cen_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    rd_d   = pop  ? rd_q + 1'b1 : rd_q;
    fcnt_d = fcnt_q;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + FW'(1);
      2'b01:   fcnt_d = fcnt_q - FW'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tcnt_q  <= '0;
      state_q <= ST_RUN;
      dac_q   <= MID;
      cen_q   <= 1'b0;
      und_q   <= 8'd0;
      rr_q    <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      fcnt_q  <= '0;
    end else begin
      tcnt_q  <= tcnt_d;
      state_q <= state_d;
      dac_q   <= dac_d;
      cen_q   <= cen_d;
      und_q   <= und_d;
      rr_q    <= rr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_q] <= push_dat;
    end
  end

  assign DAC_DATA = dac_q;
  assign DAC_CEN  = cen_q;
  assign MUTED    = (state_q == ST_MUTED);
  assign UNDERRUN = und_q;

endmodule
